// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage: multi-cycle MULT/DIV with architectural HI/LO.
// Results are committed on the last busy edge; HI/LO reads never see an in-flight result.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_data1,
    input  logic [31:0] E_data2,
    input  logic [3:0]  E_mdu_op,
    input  logic        E_req,
    output logic        E_start,
    output logic        E_busy,
    output logic [31:0] E_mdu_out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         op_r;
    logic [31:0]        a_r;
    logic [31:0]        b_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;

    logic               is_long_s;
    logic               is_mult_s;
    logic               start_s;
    logic               finish_s;
    logic               mt_hi_s;
    logic               mt_lo_s;
    logic [63:0]        prod_s;
    logic [31:0]        div_n_s;
    logic [31:0]        div_d_s;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic               res_we_s;
    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;
    logic [31:0]        mdu_out_s;

    function automatic logic [31:0] mag32(input logic [31:0] x);
        mag32 = x[31] ? (32'd0 - x) : x;
    endfunction

    // Decode the incoming op; long ops only start while idle.
    always_comb begin
        is_long_s = 1'b0;
        is_mult_s = 1'b0;
        case (E_mdu_op)
            OP_MULT, OP_MULTU: begin
                is_long_s = 1'b1;
                is_mult_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                is_long_s = 1'b1;
                is_mult_s = 1'b0;
            end
            default: begin
                is_long_s = 1'b0;
                is_mult_s = 1'b0;
            end
        endcase
        start_s  = E_req & is_long_s & (state_r == ST_IDLE);
        mt_hi_s  = E_req & (E_mdu_op == OP_MTHI) & (state_r == ST_IDLE);
        mt_lo_s  = E_req & (E_mdu_op == OP_MTLO) & (state_r == ST_IDLE);
        finish_s = (state_r == ST_RUN) & (cnt_r <= CNT_W'(1));
    end

    // Datapath from latched operands; signed divide works on magnitudes so MIN/-1 wraps cleanly.
    always_comb begin
        if (op_r == OP_MULT) begin
            prod_s = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
        end else begin
            prod_s = {32'd0, a_r} * {32'd0, b_r};
        end
        if (op_r == OP_DIV) begin
            div_n_s = mag32(a_r);
            div_d_s = mag32(b_r);
        end else begin
            div_n_s = a_r;
            div_d_s = b_r;
        end
        if (div_d_s != 32'd0) begin
            quo_s = div_n_s / div_d_s;
            rem_s = div_n_s % div_d_s;
        end else begin
            quo_s = 32'd0;
            rem_s = 32'd0;
        end
        if ((op_r == OP_DIV) && (a_r[31] ^ b_r[31])) begin
            quo_s = 32'd0 - quo_s;
        end else begin
            quo_s = quo_s;
        end
        if ((op_r == OP_DIV) && a_r[31]) begin
            rem_s = 32'd0 - rem_s;
        end else begin
            rem_s = rem_s;
        end
    end

    // Select what gets committed to HI/LO when the run completes.
    always_comb begin
        res_we_s = 1'b0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                res_we_s = 1'b1;
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            OP_DIV, OP_DIVU: begin
                // A zero divisor leaves HI/LO untouched but still spends the full latency.
                if (b_r != 32'd0) begin
                    res_we_s = 1'b1;
                    res_hi_s = rem_s;
                    res_lo_s = quo_s;
                end else begin
                    res_we_s = 1'b0;
                end
            end
            default: begin
                res_we_s = 1'b0;
            end
        endcase
    end

    // Control FSM: operand latch, latency counter and IDLE/RUN state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            op_r    <= 4'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_RUN;
                        op_r    <= E_mdu_op;
                        a_r     <= E_data1;
                        b_r     <= E_data2;
                        cnt_r   <= is_mult_s ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Architectural HI/LO: result commit or MTHI/MTLO while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (finish_s && res_we_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (mt_hi_s) begin
            hi_r <= E_data1;
        end else if (mt_lo_s) begin
            lo_r <= E_data1;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Move-from read port reflects committed HI/LO only.
    always_comb begin
        mdu_out_s = 32'd0;
        case (E_mdu_op)
            OP_MFHI: mdu_out_s = hi_r;
            OP_MFLO: mdu_out_s = lo_r;
            default: mdu_out_s = 32'd0;
        endcase
    end

    assign E_start   = start_s;
    assign E_busy    = (state_r == ST_RUN);
    assign E_mdu_out = mdu_out_s;
    assign E_HI      = hi_r;
    assign E_LO      = lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: products, quotients, hazards and mid-run reset.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] E_data1 = 32'd0;
    logic [31:0] E_data2 = 32'd0;
    logic [3:0]  E_mdu_op = 4'd0;
    logic        E_req = 1'b0;
    logic        E_start;
    logic        E_busy;
    logic [31:0] E_mdu_out;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int vectors = 0;
    int miscompares = 0;

    e_mdu dut (
        .clk       (clk),
        .reset     (reset),
        .E_data1   (E_data1),
        .E_data2   (E_data2),
        .E_mdu_op  (E_mdu_op),
        .E_req     (E_req),
        .E_start   (E_start),
        .E_busy    (E_busy),
        .E_mdu_out (E_mdu_out),
        .E_HI      (E_HI),
        .E_LO      (E_LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one op for one cycle, check E_start, return at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic exp_start, input string tag);
        @(negedge clk);
        E_req    = 1'b1;
        E_mdu_op = op;
        E_data1  = d1;
        E_data2  = d2;
        #1 check({tag, "_start"}, 32'(E_start), 32'(exp_start));
        @(negedge clk);
        E_req    = 1'b0;
        E_mdu_op = 4'd0;
    endtask

    // Count busy cycles (bounded) from the current negedge.
    task automatic wait_idle(input int exp_len, input string tag);
        int n = 0;
        while (E_busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp_len));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        E_mdu_op = 4'd5;
        #1;
        check("rst_hi", E_HI, 32'h0);
        check("rst_lo", E_LO, 32'h0);
        check("rst_busy", 32'(E_busy), 32'h0);
        check("rst_out", E_mdu_out, 32'h0);
        E_mdu_op = 4'd0;
        @(negedge clk);
        reset = 1'b1;

        issue(4'd1, 32'hFFFFFFFE, 32'h00000003, 1'b1, "mult");
        wait_idle(5, "mult_busy");
        check("mult_hi", E_HI, 32'hFFFFFFFF);
        check("mult_lo", E_LO, 32'hFFFFFFFA);

        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "multu");
        wait_idle(5, "multu_busy");
        check("multu_hi", E_HI, 32'hFFFFFFFE);
        check("multu_lo", E_LO, 32'h00000001);
        E_req = 1'b1; E_mdu_op = 4'd5;
        #1 check("mfhi", E_mdu_out, 32'hFFFFFFFE);
        E_mdu_op = 4'd6;
        #1 check("mflo", E_mdu_out, 32'h00000001);
        E_req = 1'b0; E_mdu_op = 4'd0;
        #1 check("out_none", E_mdu_out, 32'h0);

        issue(4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1, "div");
        wait_idle(10, "div_busy");
        check("div_lo", E_LO, 32'hFFFFFFFD);
        check("div_hi", E_HI, 32'hFFFFFFFF);

        issue(4'd3, 32'h00000007, 32'hFFFFFFFE, 1'b1, "div2");
        wait_idle(10, "div2_busy");
        check("div2_lo", E_LO, 32'hFFFFFFFD);
        check("div2_hi", E_HI, 32'h00000001);

        issue(4'd4, 32'd100, 32'd7, 1'b1, "divu");
        wait_idle(10, "divu_busy");
        check("divu_lo", E_LO, 32'd14);
        check("divu_hi", E_HI, 32'd2);

        issue(4'd7, 32'h12345678, 32'h0, 1'b0, "mthi");
        check("mthi_hi", E_HI, 32'h12345678);
        issue(4'd8, 32'h12345678, 32'h0, 1'b0, "mtlo");
        check("mtlo_lo", E_LO, 32'h12345678);
        issue(4'd4, 32'd7, 32'd0, 1'b1, "divz");
        wait_idle(10, "divz_busy");
        check("divz_hi", E_HI, 32'h12345678);
        check("divz_lo", E_LO, 32'h12345678);

        issue(4'd8, 32'hCAFEBABE, 32'h0, 1'b0, "mtlo2");
        check("mtlo2_lo", E_LO, 32'hCAFEBABE);
        check("mtlo2_hi", E_HI, 32'h12345678);

        // Hazards during RUN: MTHI and a second MULT must be ignored, operand changes harmless.
        issue(4'd1, 32'd5, 32'd6, 1'b1, "multb");
        E_req = 1'b1; E_mdu_op = 4'd7; E_data1 = 32'h1;
        #1 check("mthi_run_start", 32'(E_start), 32'h0);
        @(negedge clk);
        check("mthi_run_hi", E_HI, 32'h12345678);
        E_mdu_op = 4'd1; E_data1 = 32'd100; E_data2 = 32'd100;
        #1 check("mult_run_start", 32'(E_start), 32'h0);
        @(negedge clk);
        E_req = 1'b0; E_mdu_op = 4'd0;
        wait_idle(3, "multb_busy");
        check("multb_lo", E_LO, 32'd30);
        check("multb_hi", E_HI, 32'd0);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, "divmin");
        E_req = 1'b1; E_mdu_op = 4'd6;
        #1 check("mflo_run", E_mdu_out, 32'd30);
        E_req = 1'b0; E_mdu_op = 4'd0;
        wait_idle(10, "divmin_busy");
        check("divmin_lo", E_LO, 32'h80000000);
        check("divmin_hi", E_HI, 32'h0);

        @(negedge clk);
        E_req = 1'b0; E_mdu_op = 4'd1; E_data1 = 32'd2; E_data2 = 32'd2;
        #1 check("noreq_start", 32'(E_start), 32'h0);
        @(negedge clk);
        check("noreq_busy", 32'(E_busy), 32'h0);
        check("noreq_lo", E_LO, 32'h80000000);
        E_req = 1'b1; E_mdu_op = 4'd9;
        #1 check("op9_start", 32'(E_start), 32'h0);
        check("op9_out", E_mdu_out, 32'h0);
        @(negedge clk);
        check("op9_busy", 32'(E_busy), 32'h0);
        E_req = 1'b0; E_mdu_op = 4'd0;

        // Reset in the 4th busy cycle of a DIV aborts it; a MULT right after release runs normally.
        issue(4'd7, 32'hAAAA5555, 32'h0, 1'b0, "mthi3");
        issue(4'd8, 32'h5555AAAA, 32'h0, 1'b0, "mtlo3");
        issue(4'd3, 32'd100, 32'd3, 1'b1, "divr");
        repeat (3) @(negedge clk);
        check("divr_busy4", 32'(E_busy), 32'h1);
        reset = 1'b0;
        #1;
        check("rstrun_busy", 32'(E_busy), 32'h0);
        check("rstrun_hi", E_HI, 32'h0);
        check("rstrun_lo", E_LO, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        E_req = 1'b1; E_mdu_op = 4'd1; E_data1 = 32'd3; E_data2 = 32'd4;
        #1 check("postrst_start", 32'(E_start), 32'h1);
        @(negedge clk);
        E_req = 1'b0; E_mdu_op = 4'd0;
        wait_idle(5, "postrst_busy");
        check("postrst_lo", E_LO, 32'd12);
        check("postrst_hi", E_HI, 32'd0);
        repeat (8) @(negedge clk);
        check("nolate_lo", E_LO, 32'd12);
        check("nolate_hi", E_HI, 32'd0);
        check("nolate_busy", 32'(E_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
